// File: rtl/arrow_pool.sv
// arrow_pool: fixed-slot player arrow manager. Spawns arrows on shoot edges, steps every
// live arrow once per frame tick, retires them on walls, map edge, age or mob strikes.
module arrow_pool #(
    parameter int N_ARROWS    = 4,
    parameter int FRAME_DIV   = 200000,
    parameter int SPEED_SHIFT = 3,
    parameter int LIFETIME    = 250
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      clear,
    input  logic                      shoot,
    input  logic [15:0]               steve_x,
    input  logic [15:0]               steve_y,
    input  logic [31:0]               tri_center,
    input  logic [255:0][4:0]         map,
    input  logic [255:0][3:0]         mob,
    output logic [N_ARROWS-1:0]       arrow_valid,
    output logic [N_ARROWS-1:0][15:0] arrow_x,
    output logic [N_ARROWS-1:0][15:0] arrow_y,
    output logic                      mob_hit,
    output logic [7:0]                mob_hit_idx,
    output logic                      spawn_drop
);

    localparam int CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SLOT_W = (N_ARROWS > 1) ? $clog2(N_ARROWS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_ARROWS - 1);
    localparam logic [7:0]        AGE_LAST  = 8'(LIFETIME - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    // A position is off the 16x16 tile map when negative or beyond tile 15.
    function automatic logic off_map(input logic signed [31:0] v);
        return |v[31:20];
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [SLOT_W-1:0]   slot_r;
    logic [SLOT_W-1:0]   slot_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                tick_s;
    logic                shoot_q_r;
    logic                edge_s;
    logic                pending_r;

    logic [N_ARROWS-1:0] valid_r;
    logic signed [31:0]  pos_x_r [N_ARROWS];
    logic signed [31:0]  pos_y_r [N_ARROWS];
    logic signed [31:0]  vel_x_r [N_ARROWS];
    logic signed [31:0]  vel_y_r [N_ARROWS];
    logic [7:0]          age_r   [N_ARROWS];

    logic                free_found_s;
    logic [SLOT_W-1:0]   free_idx_s;
    logic                do_spawn_s;
    logic                do_drop_s;
    logic                do_step_s;
    logic                consume_s;

    logic signed [31:0]  sin_ext_s;
    logic signed [31:0]  cos_ext_s;
    logic signed [31:0]  spawn_vx_s;
    logic signed [31:0]  spawn_vy_s;
    logic signed [31:0]  nx_s;
    logic signed [31:0]  ny_s;
    logic [7:0]          tile_s;
    logic                out_s;
    logic                aged_s;
    logic                wall_s;
    logic                mob_s;
    logic                tie_unused;

    assign tick_s     = (cnt_r == CNT_LAST);
    assign edge_s     = shoot & ~shoot_q_r;
    assign sin_ext_s  = {{16{tri_center[31]}}, tri_center[31:16]};
    assign cos_ext_s  = {{16{tri_center[15]}}, tri_center[15:0]};
    assign spawn_vx_s = cos_ext_s <<< SPEED_SHIFT;
    assign spawn_vy_s = 32'sd0 - (sin_ext_s <<< SPEED_SHIFT);
    assign tie_unused = ^{map, mob};

    // Frame tick divider; clear deliberately leaves the frame phase alone.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Shoot edge detect and single-entry pending request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shoot_q_r <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            shoot_q_r <= shoot;
            if (clear) begin
                pending_r <= 1'b0;
            end else if (consume_s) begin
                pending_r <= edge_s;
            end else begin
                pending_r <= pending_r | edge_s;
            end
        end
    end

    // Lowest-index free slot: scanning downwards lets the lowest index win.
    always_comb begin
        free_found_s = ~&valid_r;
        free_idx_s   = '0;
        for (int i = N_ARROWS - 1; i >= 0; i--) begin
            free_idx_s = valid_r[i] ? free_idx_s : SLOT_W'(i);
        end
    end

    // Candidate move of the slot currently being updated.
    always_comb begin
        nx_s   = pos_x_r[slot_r] + vel_x_r[slot_r];
        ny_s   = pos_y_r[slot_r] + vel_y_r[slot_r];
        tile_s = {ny_s[19:16], nx_s[19:16]};
        out_s  = off_map(nx_s) | off_map(ny_s);
        aged_s = (age_r[slot_r] == AGE_LAST);
        wall_s = map[tile_s][4];
        mob_s  = mob[tile_s][3];
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            state_r <= ST_IDLE;
            slot_r  <= '0;
        end else begin
            state_r <= next_state_s;
            slot_r  <= slot_next_s;
        end
    end

    // FSM next state: tick beats a pending spawn; update walks one slot per cycle.
    always_comb begin
        next_state_s = state_r;
        slot_next_s  = slot_r;
        do_spawn_s   = 1'b0;
        do_drop_s    = 1'b0;
        do_step_s    = 1'b0;
        consume_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    next_state_s = ST_UPDATE;
                    slot_next_s  = '0;
                end else if (pending_r) begin
                    consume_s  = 1'b1;
                    do_spawn_s = free_found_s;
                    do_drop_s  = ~free_found_s;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                do_step_s = 1'b1;
                if (slot_r == SLOT_LAST) begin
                    next_state_s = ST_IDLE;
                    slot_next_s  = '0;
                end else begin
                    slot_next_s = slot_r + SLOT_W'(1);
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                slot_next_s  = '0;
            end
        endcase
    end

    // Slot pool: spawn, per-slot update with ordered retire checks, hit/drop pulses.
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            valid_r     <= '0;
            mob_hit     <= 1'b0;
            mob_hit_idx <= 8'h00;
            spawn_drop  <= 1'b0;
            for (int i = 0; i < N_ARROWS; i++) begin
                pos_x_r[i] <= 32'sd0;
                pos_y_r[i] <= 32'sd0;
                vel_x_r[i] <= 32'sd0;
                vel_y_r[i] <= 32'sd0;
                age_r[i]   <= 8'd0;
            end
        end else begin
            mob_hit    <= 1'b0;
            spawn_drop <= do_drop_s;
            if (do_spawn_s) begin
                valid_r[free_idx_s] <= 1'b1;
                pos_x_r[free_idx_s] <= {8'h00, steve_x, 8'h00};
                pos_y_r[free_idx_s] <= {8'h00, steve_y, 8'h00};
                vel_x_r[free_idx_s] <= spawn_vx_s;
                vel_y_r[free_idx_s] <= spawn_vy_s;
                age_r[free_idx_s]   <= 8'd0;
            end else if (do_step_s && valid_r[slot_r]) begin
                if (out_s || aged_s || wall_s) begin
                    valid_r[slot_r] <= 1'b0;
                end else if (mob_s) begin
                    valid_r[slot_r] <= 1'b0;
                    mob_hit         <= 1'b1;
                    mob_hit_idx     <= tile_s;
                end else begin
                    pos_x_r[slot_r] <= nx_s;
                    pos_y_r[slot_r] <= ny_s;
                    age_r[slot_r]   <= age_r[slot_r] + 8'd1;
                end
            end
        end
    end

    assign arrow_valid = valid_r;

    // Renderer view: 8.8 window of each 16.16 position register.
    always_comb begin
        for (int i = 0; i < N_ARROWS; i++) begin
            arrow_x[i] = pos_x_r[i][23:8];
            arrow_y[i] = pos_y_r[i][23:8];
        end
    end

endmodule

// File: tb/tb_arrow_pool.sv
// Bench for arrow_pool: a spec-level slot model checked every cycle, plus
// directed scenarios with hand-computed positions, tick counts and hit orders.
module tb_arrow_pool;
    localparam int N  = 4;
    localparam int FD = 16;
    localparam int SS = 3;
    localparam int LT = 250;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               shoot;
    logic [15:0]        sx;
    logic [15:0]        sy;
    logic [31:0]        tri_c;
    logic [255:0][4:0]  map;
    logic [255:0][3:0]  mob;
    logic [N-1:0]       arrow_valid;
    logic [N-1:0][15:0] arrow_x;
    logic [N-1:0][15:0] arrow_y;
    logic               mob_hit;
    logic [7:0]         mob_hit_idx;
    logic               spawn_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arrow_pool #(.N_ARROWS(N), .FRAME_DIV(FD), .SPEED_SHIFT(SS), .LIFETIME(LT)) dut (
        .Clk(clk), .Reset(rst), .clear(clear), .shoot(shoot),
        .steve_x(sx), .steve_y(sy), .tri_center(tri_c), .map(map), .mob(mob),
        .arrow_valid(arrow_valid), .arrow_x(arrow_x), .arrow_y(arrow_y),
        .mob_hit(mob_hit), .mob_hit_idx(mob_hit_idx), .spawn_drop(spawn_drop)
    );

    // Model state: arrows as plain integers in 1/65536 tile units.
    bit     m_v   [N];
    longint m_x   [N];
    longint m_y   [N];
    longint m_vx  [N];
    longint m_vy  [N];
    int     m_age [N];
    int     m_ph, m_upd, n_ticks, e_idx;
    bit     m_pend, m_prev, e_hit, e_drop, mvalid;
    longint cyc;
    int     drop_cnt;
    int     hit_idx_q[$];
    longint hit_cyc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_age[i] = 0;
        end
        m_pend = 0; m_upd = -1; e_hit = 0; e_drop = 0; e_idx = 0;
    endtask

    task automatic m_step(input int i);
        longint nx, ny;
        int tile;
        if (m_v[i]) begin
            nx = m_x[i] + m_vx[i];
            ny = m_y[i] + m_vy[i];
            if (nx < 0 || ny < 0 || nx >= 1048576 || ny >= 1048576) m_v[i] = 0;
            else if (m_age[i] == LT - 1) m_v[i] = 0;
            else begin
                tile = int'(ny / 65536) * 16 + int'(nx / 65536);
                if (map[tile][4]) m_v[i] = 0;
                else if (mob[tile][3]) begin
                    m_v[i] = 0; e_hit = 1; e_idx = tile;
                end else begin
                    m_x[i] = nx; m_y[i] = ny; m_age[i] = m_age[i] + 1;
                end
            end
        end
    endtask

    task automatic m_spawn();
        shortint c, s;
        int slot;
        slot = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) slot = i;
        if (slot < 0) e_drop = 1;
        else begin
            c = tri_c[15:0];
            s = tri_c[31:16];
            m_v[slot]   = 1;
            m_x[slot]   = longint'(sx) * 256;
            m_y[slot]   = longint'(sy) * 256;
            m_vx[slot]  = longint'(c) * (1 << SS);
            m_vy[slot]  = -(longint'(s) * (1 << SS));
            m_age[slot] = 0;
        end
    endtask

    // Model advance: one clock of the spec's behaviour, using the inputs seen at this edge.
    always @(posedge clk) begin
        bit tick, edg;
        if (rst) begin
            m_clear();
            m_ph = 0; m_prev = 0; mvalid = 1;
        end else begin
            cyc++;
            tick = (m_ph == FD - 1);
            m_ph = tick ? 0 : m_ph + 1;
            if (tick) n_ticks++;
            edg = shoot && !m_prev;
            m_prev = shoot;
            e_hit = 0; e_drop = 0;
            if (clear) m_clear();
            else if (m_upd >= 0) begin
                m_step(m_upd);
                m_upd = (m_upd == N - 1) ? -1 : m_upd + 1;
                if (edg) m_pend = 1;
            end else if (tick) begin
                m_upd = 0;
                if (edg) m_pend = 1;
            end else if (m_pend) begin
                m_spawn();
                m_pend = edg;
            end else m_pend = edg;
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("valid[%0d]", i), 64'(arrow_valid[i]), 64'(m_v[i]));
                chk($sformatf("x[%0d]", i), 64'(arrow_x[i]), 64'(16'(m_x[i] / 256)));
                chk($sformatf("y[%0d]", i), 64'(arrow_y[i]), 64'(16'(m_y[i] / 256)));
            end
            chk("mob_hit", 64'(mob_hit), 64'(e_hit));
            if (e_hit) chk("mob_hit_idx", 64'(mob_hit_idx), 64'(e_idx));
            chk("spawn_drop", 64'(spawn_drop), 64'(e_drop));
            if (mob_hit === 1'b1) begin
                hit_idx_q.push_back(int'(mob_hit_idx));
                hit_cyc_q.push_back(cyc);
            end
            if (spawn_drop === 1'b1) drop_cnt++;
        end
    end

    task automatic wait_phase(input int p);
        bit ok = 0;
        for (int k = 0; k < 4 * FD && !ok; k++) begin
            if (m_ph == p) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_phase: phase %0d never reached, at %0d", p, m_ph);
        end
    endtask

    // Wait for k more ticks, then for the end of that frame's update pass.
    task automatic wait_frames(input int k);
        int target;
        bit ok = 0;
        target = n_ticks + k;
        for (int c = 0; c < (k + 1) * FD + 4 && !ok; c++) begin
            if (n_ticks >= target) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_frames: got %0d ticks, required %0d", n_ticks, target);
        end
        wait_phase(N);
    endtask

    task automatic edge_shoot();
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
        @(negedge clk);
    endtask

    task automatic life_ticks(input int limit, output int n);
        n = 0;
        for (int k = 0; k < limit; k++) begin
            wait_frames(1);
            n++;
            if (!arrow_valid[0]) break;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n, base, dbase;
        rst = 1'b1; clear = 1'b0; shoot = 1'b0;
        sx = 16'h0180; sy = 16'h0180; tri_c = 32'h0000_0100;
        map = '0; mob = '0;
        cyc = 0; n_ticks = 0; drop_cnt = 0; mvalid = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", 64'(arrow_valid), 64'h0);
        chk("reset_hit_idx", 64'(mob_hit_idx), 64'h0);

        // Basic spawn and one step of +x motion.
        edge_shoot();
        chk("spawn_valid", 64'(arrow_valid), 64'h1);
        chk("spawn_x", 64'(arrow_x[0]), 64'h0180);
        wait_frames(1);
        chk("step_x", 64'(arrow_x[0]), 64'h0188);
        chk("step_y", 64'(arrow_y[0]), 64'h0180);

        // Pool exhaustion: four spawns then one drop.
        do_clear();
        tri_c = 32'h0;
        wait_phase(N);
        dbase = drop_cnt;
        repeat (5) edge_shoot();
        repeat (3) @(negedge clk);
        chk("pool_full", 64'(arrow_valid), 64'hF);
        chk("drop_pulses", 64'(drop_cnt - dbase), 64'd1);

        // Wall at tile {1,2}: 16 ticks from x=1.5 at 1/32 tile per tick.
        do_clear();
        map[8'h12][4] = 1'b1;
        tri_c = 32'h0000_0100; sx = 16'h0180; sy = 16'h0180;
        base = hit_idx_q.size();
        wait_phase(N);
        edge_shoot();
        life_ticks(40, n);
        chk("wall_ticks", 64'(n), 64'd16);
        chk("wall_last_x", 64'(arrow_x[0]), 64'h01F8);
        chk("wall_no_hit", 64'(hit_idx_q.size() - base), 64'd0);
        map = '0;

        // Two mob strikes in one tick, reported in slot order.
        do_clear();
        mob[8'h25][3] = 1'b1;
        mob[8'h27][3] = 1'b1;
        sy = 16'h0280;
        wait_phase(N);
        sx = 16'h04FC;
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
        @(negedge clk);
        sx = 16'h06FC;
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
        @(negedge clk);
        base = hit_idx_q.size();
        wait_frames(1);
        chk("hit_count", 64'(hit_idx_q.size() - base), 64'd2);
        if (hit_idx_q.size() >= base + 2) begin
            chk("hit0_idx", 64'(hit_idx_q[base]), 64'h25);
            chk("hit1_idx", 64'(hit_idx_q[base + 1]), 64'h27);
            chk("hit_gap", 64'(hit_cyc_q[base + 1] - hit_cyc_q[base]), 64'd1);
        end
        mob = '0;

        // Stationary arrow expires after exactly LIFETIME ticks.
        do_clear();
        tri_c = 32'h0; sx = 16'h0180; sy = 16'h0180;
        wait_phase(N);
        edge_shoot();
        life_ticks(300, n);
        chk("lifetime_ticks", 64'(n), 64'd250);

        // -y from y=0x0010: 0x08, 0x00, then negative on the third tick.
        do_clear();
        tri_c = 32'h0100_0000; sy = 16'h0010;
        wait_phase(N);
        edge_shoot();
        life_ticks(20, n);
        chk("neg_y_ticks", 64'(n), 64'd3);
        chk("neg_y_last", 64'(arrow_y[0]), 64'h0000);

        // Shoot edge on the tick cycle: the spawn waits out the update pass.
        do_clear();
        tri_c = 32'h0000_0100; sx = 16'h0180; sy = 16'h0180;
        wait_phase(FD - 1);
        shoot = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            shoot = 1'b0;
            n++;
            if (arrow_valid[0]) break;
        end
        chk("tick_spawn_delay", 64'(n), 64'(N + 2));

        // Clear while the mob-bound slot 1 is being updated.
        mob[8'h25][3] = 1'b1;
        sx = 16'h04FC; sy = 16'h0280;
        wait_phase(N);
        edge_shoot();
        base = hit_idx_q.size();
        n = 0;
        for (int k = 0; k < 3 * FD && m_upd != 1; k++) @(negedge clk);
        chk("reached_slot1", 64'(m_upd), 64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_valid", 64'(arrow_valid), 64'h0);
        repeat (4) @(negedge clk);
        chk("clear_no_hit", 64'(hit_idx_q.size() - base), 64'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arrow_pool.md
Name: arrow_pool

Overview:
- Player-arrow manager directly downstream of the player controller.
- Consumes the controller's shoot pulse, its position (steve_x/steve_y) and the {sin,cos} heading word. Spawns arrows into a fixed slot pool and advances them at frame rate.
- Retires arrows on walls, map edge or lifetime expiry. Reports mob hits to the mob logic and exposes arrow positions to the renderer.

Parameters:
- N_ARROWS, 4, number of arrow slots (1..8).
- FRAME_DIV, 200000, Clk cycles per frame tick (must be > N_ARROWS+2).
- SPEED_SHIFT, 3, per-tick velocity = heading component << SPEED_SHIFT.
- LIFETIME, 250, ticks before an arrow self-retires.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of all slots (tied to controller respawn).
- shoot  in  1  release request; rising edge = one spawn.
- steve_x  in  16  player x, 8.8 fixed (tile in [11:8]).
- steve_y  in  16  player y, 8.8 fixed.
- tri_center  in  32  {sin[31:16], cos[15:0]}, signed, same units as position fraction.
- map  in  256x5  tile map; bit4 = solid; index {y_tile, x_tile}.
- mob  in  256x4  mob occupancy; bit3 = occupied; same index.
- arrow_valid  out  N_ARROWS  slot live flags.
- arrow_x  out  N_ARROWSx16  per-slot x, 8.8 (pos[23:8]).
- arrow_y  out  N_ARROWSx16  per-slot y, 8.8.
- mob_hit  out  1  one-Clk pulse per arrow striking a mob.
- mob_hit_idx  out  8  {y_tile, x_tile} of struck mob, valid with mob_hit.
- spawn_drop  out  1  one-Clk pulse when a spawn is rejected because the pool is full.

Behaviour:
- Reset or clear (both synchronous): all valid=0, pos=0, vel=0, age=0, pending=0, state=IDLE, tick counter=0, mob_hit=0, mob_hit_idx=0, spawn_drop=0. clear does not reset the tick counter.
- Tick: counter 0..FRAME_DIV-1; tick asserts for one Clk when counter == FRAME_DIV-1, then the counter wraps to 0.
- Shoot edge: shoot is registered, and edge = shoot & ~shoot_q. An edge sets pending. A second edge while pending is already set is lost (no queue).
- Per-slot state: pos_x/pos_y 32-bit signed 16.16; vel_x/vel_y 32-bit signed; age 8-bit.
- FSM IDLE:
  - If tick: go to UPDATE with slot=0. Tick has priority over spawn.
  - Else if pending: spawn into the lowest-index free slot and clear pending.
  - Spawn values: pos_x = {8'h0, steve_x, 8'h0}; pos_y likewise; vel_x = sext(cos) << SPEED_SHIFT; vel_y = -(sext(sin) << SPEED_SHIFT); age = 0; valid = 1.
  - Spawned arrow is visible on the outputs the next Clk.
  - If no slot is free: pulse spawn_drop, clear pending.
- FSM UPDATE (one slot per Clk, slot 0..N_ARROWS-1, then IDLE):
  - Invalid slot: no change.
  - Valid slot: nx = pos_x + vel_x, ny = pos_y + vel_y. Check in order, first match wins:
    1. nx or ny negative, or bits [31:20] nonzero → retire.
    2. age == LIFETIME-1 → retire.
    3. map[{ny[19:16], nx[19:16]}][4] → retire.
    4. mob[{ny[19:16], nx[19:16]}][3] → retire; mob_hit=1 and mob_hit_idx=that index in this same registered cycle (visible next Clk).
    5. Otherwise pos <= (nx, ny), age += 1.
  - Retired slots keep their last pos, valid=0.
  - Multiple hits in one tick produce separate mob_hit pulses on consecutive cycles, in slot order.
- Latency: tick to slot k updated = k+1 Clk. Edge during UPDATE waits; it spawns in the first IDLE cycle after UPDATE.
- Slot freed in an UPDATE is reusable by a spawn in the following IDLE.
- clear or Reset mid-UPDATE aborts immediately to IDLE with all slots empty.
- arrow_x = pos_x[23:8], arrow_y = pos_y[23:8], registered outputs.

Test Plan:
- Reset, shoot 0→1 with steve_x=0x0180, steve_y=0x0180, tri_center={16'h0000,16'h0100}, empty map → slot0 valid, arrow_x=0x0180; after 1 tick arrow_x=0x0188, arrow_y unchanged.
- Five shoot edges with N_ARROWS=4, no ticks → slots 0-3 valid, fifth edge gives exactly one spawn_drop pulse.
- Arrow heading +x from tile x=1 with map solid at {y=1,x=2} → retires on the tick whose nx tile = 2, valid=0, no mob_hit.
- Two arrows reaching mob tiles 0x25 and 0x27 in the same tick → mob_hit pulses on two consecutive Clk, idx 0x25 then 0x27 (slot order).
- Arrow with zero heading (tri_center=0) → retires after exactly LIFETIME=250 ticks; arrow heading −y from y tile 0 → retires on first negative ny.
- Shoot edge coinciding with tick → UPDATE runs first, spawn occurs in cycle N_ARROWS+1 after tick; assert clear mid-UPDATE → all valid=0 the next Clk, no mob_hit.
